// File: rtl/aes_ctrl_seq.sv
// Sequencer between a request/response handshake and an iterative AES core.
// It caches the decryption key schedule. Define AES_SEQ_TIMEOUT_EN to add a watchdog on core waits.
module aes_ctrl_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_mode,
  input  logic [127:0] req_key,
  input  logic [127:0] req_text,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_text,
  output logic         rsp_mode,
  output logic         rsp_err,
  output logic         core_mode,
  output logic         core_ld,
  output logic         core_kld,
  output logic [127:0] core_key,
  output logic [127:0] core_text_in,
  input  logic         core_done,
  input  logic         core_kdone,
  input  logic [127:0] core_text_out,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KLOAD = 3'd1,
    KWAIT = 3'd2,
    LOAD  = 3'd3,
    RUN   = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t       state, state_nxt;
  logic         mode_q;
  logic [127:0] key_q;
  logic [127:0] text_q;
  logic [127:0] rsp_text_q;
  logic [127:0] cache_key_q;
  logic         key_vld_q;
  logic         accept;
  logic         key_hit;
  logic         done_evt;
  logic         tmo_evt;

  assign accept   = (state == IDLE) && req_valid;
  assign key_hit  = key_vld_q && (req_key == cache_key_q);
  assign done_evt = ((state == KWAIT) && core_kdone) || ((state == RUN) && core_done);

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // Counter is cleared in the single-cycle state preceding each wait state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if ((state == KLOAD) || (state == LOAD)) begin
      tmo_cnt <= '0;
    end else if ((state == KWAIT) || (state == RUN)) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign tmo_evt = ((state == KWAIT) || (state == RUN)) && !done_evt &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (tmo_evt) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  assign tmo_evt = 1'b0;
  // The error flag cannot be raised without the watchdog; the term only keeps the parameter referenced.
  assign rsp_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!req_mode || key_hit) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = KLOAD;
          end
        end
      end
      KLOAD: state_nxt = KWAIT;
      KWAIT: begin
        if (core_kdone) begin
          state_nxt = LOAD;
        end else if (tmo_evt) begin
          state_nxt = RESP;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (core_done || tmo_evt) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = 1'b0;
    core_kld  = 1'b0;
    core_ld   = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      KLOAD:   core_kld  = 1'b1;
      LOAD:    core_ld   = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture, key cache and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 1'b0;
      key_q       <= '0;
      text_q      <= '0;
      rsp_text_q  <= '0;
      cache_key_q <= '0;
      key_vld_q   <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= req_mode;
        key_q  <= req_key;
        text_q <= req_text;
      end
      if ((state == KWAIT) && core_kdone) begin
        key_vld_q   <= 1'b1;
        cache_key_q <= key_q;
      end
      if ((state == RUN) && core_done) begin
        rsp_text_q <= core_text_out;
      end
      if (tmo_evt) begin
        rsp_text_q <= '0;
        key_vld_q  <= 1'b0;
      end
    end
  end

  assign core_mode    = mode_q;
  assign core_key     = key_q;
  assign core_text_in = text_q;
  assign rsp_text     = rsp_text_q;
  assign rsp_mode     = mode_q;

endmodule

// File: tb/tb_aes_ctrl_seq.sv
// Scoreboard bench for aes_ctrl_seq with a behavioural core model.
// Honours AES_SEQ_TIMEOUT_EN for the watchdog scenario.
module tb_aes_ctrl_seq;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 255;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_mode;
  logic [127:0] req_key, req_text;
  logic         rsp_valid, rsp_ready, rsp_mode, rsp_err;
  logic [127:0] rsp_text;
  logic         core_mode, core_ld, core_kld, core_done, core_kdone;
  logic [127:0] core_key, core_text_in, core_text_out;
  logic         busy;

  typedef struct {
    logic [127:0] text;
    logic         mode;
    logic         err;
    int           kld_n;
    int           ld_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   kld_seen = 0;
  int   ld_seen  = 0;

  // Core model state
  logic         core_en = 1'b1;
  logic         stray   = 1'b0;
  logic         done_m, kdone_m;
  logic [127:0] out_m;
  int           t_run, t_key;

  always #5 clk = ~clk;

  aes_ctrl_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_key(req_key), .req_text(req_text),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text),
    .rsp_mode(rsp_mode), .rsp_err(rsp_err),
    .core_mode(core_mode), .core_ld(core_ld), .core_kld(core_kld),
    .core_key(core_key), .core_text_in(core_text_in),
    .core_done(core_done), .core_kdone(core_kdone), .core_text_out(core_text_out),
    .busy(busy)
  );

  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k, input logic [127:0] t);
    return t ^ {k[63:0], k[127:64]} ^ {128{m}};
  endfunction

  assign core_done     = done_m | stray;
  assign core_kdone    = kdone_m;
  assign core_text_out = stray ? 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0 : out_m;

  // Core: result 10 cycles after core_ld, key schedule 3 cycles after core_kld
  always @(posedge clk) begin
    done_m  <= 1'b0;
    kdone_m <= 1'b0;
    if (rst) begin
      t_run <= 0;
      t_key <= 0;
      out_m <= '0;
    end else begin
      if (core_ld && core_en) begin
        t_run <= 10;
      end else if (t_run > 0) begin
        t_run <= t_run - 1;
        if (t_run == 1) begin
          done_m <= 1'b1;
          out_m  <= core_fn(core_mode, core_key, core_text_in);
        end
      end
      if (core_kld && core_en) begin
        t_key <= 3;
      end else if (t_key > 0) begin
        t_key <= t_key - 1;
        if (t_key == 1) kdone_m <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: counts core pulses and checks each response handshake against the queue
  always @(negedge clk) begin
    if (rst) begin
      kld_seen = 0;
      ld_seen  = 0;
    end else begin
      if (core_kld) kld_seen++;
      if (core_ld) ld_seen++;
      if (core_ld && core_kld) begin
        n_fail++;
        $display("FAIL ld_kld_overlap: both high at %0t", $time);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: text %h with empty scoreboard", rsp_text);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_text", rsp_text, e.text);
          chk("rsp_mode", 128'(rsp_mode), 128'(e.mode));
          chk("rsp_err", 128'(rsp_err), 128'(e.err));
          chk("kld_pulses", 128'(kld_seen), 128'(e.kld_n));
          chk("ld_pulses", 128'(ld_seen), 128'(e.ld_n));
        end
        kld_seen = 0;
        ld_seen  = 0;
      end
    end
  end

  // All stimulus tasks start and end at posedge + 1
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [127:0] k, input logic [127:0] t,
                      input int kld, input logic err);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 300) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_mode  = m;
    req_key   = k;
    req_text  = t;
    e.text  = err ? 128'h0 : core_fn(m, k, t);
    e.mode  = m;
    e.err   = err;
    e.kld_n = kld;
    e.ld_n  = 1;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk("rsp_arrived", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  localparam logic [127:0] K0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] K2 = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] T0 = 128'h00112233445566778899AABBCCDDEEFF;

  initial begin
    logic [127:0] held;
    logic         bad;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mode  = 1'b0;
    req_key   = '0;
    req_text  = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready", 128'(req_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_core_ld_kld", 128'({core_ld, core_kld}), 128'(0));
    chk("rst_rsp_text", rsp_text, 128'h0);
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_core_text_in", core_text_in, 128'h0);
    chk("rst_rsp_flags", 128'({rsp_mode, rsp_err, core_mode}), 128'(0));
    rst = 1'b0;
    tick();

    // Stray done while idle
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (3) tick();
    chk("stray_idle_busy", 128'(busy), 128'(0));
    chk("stray_idle_rsp", 128'(rsp_valid), 128'(0));

    // Encrypt with stray done during the LOAD cycle
    send(1'b0, K0, T0, 0, 1'b0);
    chk("load_cycle_ld", 128'(core_ld), 128'(1));
    stray = 1'b1;
    tick();
    stray = 1'b0;
    wait_rsp();

    // Key cache: miss, hit, miss on new key
    send(1'b1, K0, 128'h0123456789ABCDEF0123456789ABCDEF, 1, 1'b0);
    wait_rsp();
    send(1'b1, K0, 128'hCAFEBABE00000000DEADBEEF11111111, 0, 1'b0);
    wait_rsp();
    send(1'b1, K1, 128'h3243F6A8885A308D313198A2E0370734, 1, 1'b0);
    wait_rsp();

    // Encrypt with response back-pressure; must not disturb the cached key
    rsp_ready = 1'b0;
    send(1'b0, K2, 128'h55555555AAAAAAAA55555555AAAAAAAA, 0, 1'b0);
    begin
      int n = 0;
      while (!rsp_valid && n < 100) begin
        tick();
        n++;
      end
    end
    held = rsp_text;
    chk("bp_held_text", held, core_fn(1'b0, K2, 128'h55555555AAAAAAAA55555555AAAAAAAA));
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 128'(rsp_valid), 128'(1));
      chk("bp_rsp_text", rsp_text, held);
      chk("bp_req_ready", 128'(req_ready), 128'(0));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle_after", 128'({req_ready, rsp_valid, busy}), 128'(3'b100));
    wait_rsp();
    send(1'b1, K1, 128'h00000000000000000000000000000001, 0, 1'b0);
    wait_rsp();

    // Reset in the middle of RUN clears the cache
    send(1'b0, K0, T0, 0, 1'b0);
    repeat (4) tick();
    chk("pre_rst_busy", 128'(busy), 128'(1));
    pulse_rst();
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("post_rst_req_ready", 128'(req_ready), 128'(1));
    repeat (12) tick();
    chk("post_rst_no_rsp", 128'(rsp_valid), 128'(0));
    send(1'b1, K1, 128'h0F0E0D0C0B0A09080706050403020100, 1, 1'b0);
    wait_rsp();

    // Core never completes
    core_en = 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
    send(1'b0, K0, T0, 0, 1'b1);
    wait_rsp();
    core_en = 1'b1;
    send(1'b1, K1, T0, 1, 1'b0);
    wait_rsp();
`else
    send(1'b0, K0, T0, 0, 1'b0);
    exp_q.delete();
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (rsp_valid) bad = 1'b1;
      tick();
    end
    chk("no_timeout_rsp", 128'(bad), 128'(0));
    chk("no_timeout_busy", 128'(busy), 128'(1));
    core_en = 1'b1;
    pulse_rst();
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
